bus_oe_arbiter: RTL and testbench
=================================

# bus_oe_arbiter

Synchronous arbiter that shares one tristate bus (a `tri` net such as BusA/BusB) between up to NREQ drivers. It grants ownership round-robin, drives each requester's active-low output enable, and inserts turnaround cycles between owners so that two drivers never enable in the same cycle. It sits beside the bus drivers: each driver gates its `assign Bus = OE_l ? 1'bz : data` with the OE_l bit this block produces.

## Interface
- NREQ, 4, number of requesters (2..8)
- MAXHOLD, 8, maximum tenure in cycles before forced handoff when another requester is waiting (1..255)
- TURN, 2, turnaround cycles with all OE_l high between owners (1..15)

- Clk  in  1  clock; all state changes on posedge
- Reset_l  in  1  reset, synchronous, active-low
- Req  in  NREQ  request per driver; level, held while bus is wanted
- Gnt  out  NREQ  one-hot grant, registered
- OE_l  out  NREQ  active-low output enable per driver, registered
- Owner  out  $clog2(NREQ)  index of current or last owner
- Busy  out  1  high whenever state is not IDLE

## Operation
- Reset values (Reset_l low at a posedge): state IDLE, Gnt=0, OE_l=all 1s, Owner=0, Busy=0, round-robin pointer=0, tenure counter=0. Reset takes effect at any posedge, including mid-tenure or mid-TURN.
- States: IDLE, OWN, TURN.
- IDLE: at a posedge with Req!=0, pick winner = first set Req bit searching upward from pointer, wrapping modulo NREQ. Go to OWN; Gnt[w]=1, OE_l[w]=0, Owner=w, tenure=1.
- OWN: tenure increments each cycle, saturating at MAXHOLD.
  - Req[Owner]=0 at a posedge -> TURN (release).
  - tenure==MAXHOLD and any other Req bit set -> TURN (preempt).
  - tenure==MAXHOLD, no other request -> stay in OWN, grant held.
  - Entering TURN: Gnt=0, OE_l all 1s, pointer=Owner+1 mod NREQ, turn counter=TURN.
- TURN: counter decrements each cycle. On the posedge ending the last turn cycle: if Req!=0, arbitrate as in IDLE and enter OWN directly; else go to IDLE.
- Arbitration samples Req only on the arbitrating edge. Bits dropped before that edge are ignored.
- A release and MAXHOLD on the same edge is treated as a release. The result is identical.
- Invariant: at most one OE_l bit is low in any cycle, and OE_l == ~Gnt (except parking, see Configuration).
- Counter widths: tenure $clog2(MAXHOLD+1), turn 4 bits. Pointer wraps NREQ-1 -> 0.

## Timing
- Grant latency from IDLE: 1 edge. Req rising before edge k gives Gnt/OE_l asserted after edge k.
- Release latency: 1 edge. Req[Owner] low before edge k gives OE_l high after edge k.
- Bus dead time between owners: exactly TURN cycles.
- Handoff period under full contention: MAXHOLD + TURN cycles.
- No combinational path from Req to any output.

## Configuration
- BUS_ARB_PARK_EN defined: bus parking is enabled.
  - On the release path (OWN -> TURN -> no request -> IDLE), OE_l[Owner] is driven low again on IDLE entry, so the bus is parked. Gnt stays 0.
  - IDLE with Req[Owner] alone: grant in 1 edge with no turnaround.
  - IDLE with any other request: OE_l all high and TURN is entered first, then arbitration runs.
  - No parking after reset until the first grant.
- BUS_ARB_PARK_EN undefined: OE_l is all 1s in IDLE and TURN; the bus floats (z) when idle.

## Test plan
All tests use NREQ=4, MAXHOLD=8, TURN=2.
- Reset: Reset_l low for 3 cycles during OWN with Req=4'hF -> after the first low edge Gnt=0, OE_l=4'hF, Busy=0, Owner=0. After release, Req=4'hF -> Gnt=4'b0001.
- Single requester: Req=4'b0010 before edge 0 -> Gnt=4'b0010, OE_l=4'b1101 after edge 0. Req low before edge 3 -> OE_l=4'hF after edge 3 for 2 cycles, then IDLE, Busy=0. Tristate bus reads z during TURN (parking off).
- Round-robin: Req=4'hF held -> Gnt sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 8 cycles, separated by 2 cycles of Gnt=0. Check never more than one OE_l low.
- No contention: Req=4'b0001 held 20 cycles -> Gnt=0001 continuously past MAXHOLD, tenure saturates, no TURN.
- Reset mid-TURN: assert Reset_l low on the edge after entering TURN -> all outputs at reset values. Pointer returns to 0, so Req=4'b1010 then grants 0010 first.
- Parking (BUS_ARB_PARK_EN): owner 2 releases with no other request -> OE_l=1011, Gnt=0 in IDLE. Req=4'b0100 -> grant in 1 edge. Req=4'b0001 -> OE_l=4'hF for 2 cycles, then Gnt=0001.

Source files
------------

// File: rtl/bus_oe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_oe_arbiter
// Purpose  : Round-robin owner arbiter for a shared tristate bus. Drives one
//            active-low OE per driver, with turnaround gaps between owners.
//            Optional bus parking on the last owner: define BUS_ARB_PARK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_oe_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAXHOLD = 8,
  parameter int TURN    = 2
) (
  input  logic                    Clk,
  input  logic                    Reset_l,
  input  logic [NREQ-1:0]         Req,
  output logic [NREQ-1:0]         Gnt,
  output logic [NREQ-1:0]         OE_l,
  output logic [$clog2(NREQ)-1:0] Owner,
  output logic                    Busy
);

  localparam int                  c_IDX_W   = $clog2(NREQ);
  localparam int                  c_TEN_W   = $clog2(MAXHOLD + 1);
  localparam logic [c_TEN_W-1:0]  c_TEN_MAX = c_TEN_W'(MAXHOLD);
  localparam logic [c_IDX_W-1:0]  c_LAST    = c_IDX_W'(NREQ - 1);
  localparam logic [NREQ-1:0]     c_ONE     = NREQ'(1);
  localparam logic [3:0]          c_TURN    = 4'(TURN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t               r_state,  w_state_n;
  logic [NREQ-1:0]      r_gnt,    w_gnt_n;
  logic [NREQ-1:0]      r_oe_l,   w_oe_l_n;
  logic [c_IDX_W-1:0]   r_owner,  w_owner_n;
  logic [c_IDX_W-1:0]   r_ptr,    w_ptr_n;
  logic [c_TEN_W-1:0]   r_tenure, w_tenure_n;
  logic [3:0]           r_turn,   w_turn_n;

  logic [c_IDX_W-1:0]   w_win;
  logic [NREQ-1:0]      w_win_oh;
  logic [NREQ-1:0]      w_owner_oh;
  logic                 w_grant;
  logic                 w_to_turn;

  // First set request at or above the pointer, wrapping modulo NREQ.
  function automatic logic [c_IDX_W-1:0] f_pick(input logic [NREQ-1:0]    req,
                                                 input logic [c_IDX_W-1:0] ptr);
    logic [c_IDX_W:0]   idx;
    logic [c_IDX_W-1:0] win;
    win = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (c_IDX_W + 1)'(i);
      if (idx >= (c_IDX_W + 1)'(NREQ)) idx = idx - (c_IDX_W + 1)'(NREQ);
      if (req[idx[c_IDX_W-1:0]]) win = idx[c_IDX_W-1:0];
    end
    return win;
  endfunction

  assign w_win      = f_pick(Req, r_ptr);
  assign w_win_oh   = c_ONE << w_win;
  assign w_owner_oh = c_ONE << r_owner;

  always_comb begin
    w_state_n  = r_state;
    w_gnt_n    = r_gnt;
    w_oe_l_n   = r_oe_l;
    w_owner_n  = r_owner;
    w_ptr_n    = r_ptr;
    w_tenure_n = r_tenure;
    w_turn_n   = r_turn;
    w_grant    = 1'b0;
    w_to_turn  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (|Req) begin
`ifdef BUS_ARB_PARK_EN
          // A parked bus must go through turnaround before anyone else drives.
          if (!(&r_oe_l) && (Req != w_owner_oh)) begin
            w_state_n = S_TURN;
            w_oe_l_n  = '1;
            w_turn_n  = c_TURN;
          end else begin
            w_grant = 1'b1;
          end
`else
          w_grant = 1'b1;
`endif
        end
      end
      S_OWN: begin
        // r_gnt is the owner one-hot while in OWN.
        if (!(|(Req & r_gnt)) || ((r_tenure == c_TEN_MAX) && |(Req & ~r_gnt))) begin
          w_to_turn = 1'b1;
        end else if (r_tenure != c_TEN_MAX) begin
          w_tenure_n = r_tenure + c_TEN_W'(1);
        end
      end
      S_TURN: begin
        if (r_turn == 4'd1) begin
          w_turn_n = '0;
          if (|Req) begin
            w_grant = 1'b1;
          end else begin
            w_state_n = S_IDLE;
`ifdef BUS_ARB_PARK_EN
            w_oe_l_n  = ~w_owner_oh;
`endif
          end
        end else begin
          w_turn_n = r_turn - 4'd1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_gnt_n   = '0;
        w_oe_l_n  = '1;
      end
    endcase

    if (w_grant) begin
      w_state_n  = S_OWN;
      w_gnt_n    = w_win_oh;
      w_oe_l_n   = ~w_win_oh;
      w_owner_n  = w_win;
      w_tenure_n = c_TEN_W'(1);
    end

    if (w_to_turn) begin
      w_state_n = S_TURN;
      w_gnt_n   = '0;
      w_oe_l_n  = '1;
      w_ptr_n   = (r_owner == c_LAST) ? '0 : r_owner + c_IDX_W'(1);
      w_turn_n  = c_TURN;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_l) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_oe_l   <= '1;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_tenure <= '0;
      r_turn   <= '0;
    end else begin
      r_state  <= w_state_n;
      r_gnt    <= w_gnt_n;
      r_oe_l   <= w_oe_l_n;
      r_owner  <= w_owner_n;
      r_ptr    <= w_ptr_n;
      r_tenure <= w_tenure_n;
      r_turn   <= w_turn_n;
    end
  end

  assign Gnt   = r_gnt;
  assign OE_l  = r_oe_l;
  assign Owner = r_owner;
  assign Busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_oe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_oe_arbiter
// Purpose  : Self-checking bench for bus_oe_arbiter (NREQ=4, MAXHOLD=8,
//            TURN=2) with directed scenarios and a random reference-model run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_oe_arbiter;

  localparam int NREQ    = 4;
  localparam int MAXHOLD = 8;
  localparam int TURN    = 2;
`ifdef BUS_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  logic       Clk;
  logic       Reset_l;
  logic [3:0] Req;
  logic [3:0] Gnt;
  logic [3:0] OE_l;
  logic [1:0] Owner;
  logic       Busy;

  int n_checks = 0;
  int n_pass   = 0;

  bus_oe_arbiter #(.NREQ(NREQ), .MAXHOLD(MAXHOLD), .TURN(TURN)) dut (
    .Clk     (Clk),
    .Reset_l (Reset_l),
    .Req     (Req),
    .Gnt     (Gnt),
    .OE_l    (OE_l),
    .Owner   (Owner),
    .Busy    (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: mode 0 idle, 1 owning, 2 turnaround.
  int m_mode, m_owner, m_ptr, m_ten, m_turn;
  bit m_parked;

  task automatic model_grant(input logic [3:0] req);
    int w;
    w = m_ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
    m_mode = 1; m_owner = w; m_ten = 1; m_parked = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] req, input logic rst_l);
    logic [3:0] own_oh;
    own_oh = 4'(1 << m_owner);
    if (!rst_l) begin
      m_mode = 0; m_owner = 0; m_ptr = 0; m_ten = 0; m_turn = 0; m_parked = 1'b0;
    end else if (m_mode == 0) begin
      if (req != 4'h0) begin
        if (PARK && m_parked && req != own_oh) begin
          m_mode = 2; m_turn = TURN; m_parked = 1'b0;
        end else model_grant(req);
      end
    end else if (m_mode == 1) begin
      if ((req & own_oh) == 4'h0 || (m_ten == MAXHOLD && (req & ~own_oh) != 4'h0)) begin
        m_mode = 2; m_turn = TURN; m_ptr = (m_owner + 1) % NREQ;
      end else if (m_ten < MAXHOLD) m_ten++;
    end else begin
      if (m_turn > 1) m_turn--;
      else if (req != 4'h0) model_grant(req);
      else begin m_mode = 0; m_parked = PARK; end
    end
  endtask

  function automatic logic [10:0] model_out();
    logic [3:0] g, oe;
    g  = (m_mode == 1) ? 4'(1 << m_owner) : 4'h0;
    oe = (m_mode == 1 || m_parked) ? ~4'(1 << m_owner) : 4'hF;
    return {g, oe, 2'(m_owner), (m_mode != 0)};
  endfunction

  task automatic tick();
    model_edge(Req, Reset_l);
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_l = 1'b0; Req = 4'h0;
    tick();
    Reset_l = 1'b1;
  endtask

  task automatic test_reset();
    Reset_l = 1'b0; Req = 4'h0;
    tick(); tick();
    n_checks++;
    if ({Gnt, OE_l, Owner, Busy} !== {4'h0, 4'hF, 2'd0, 1'b0})
      $display("FAIL reset_initial: got %h want %h", {Gnt, OE_l, Owner, Busy}, {4'h0, 4'hF, 2'd0, 1'b0});
    else n_pass++;
    Reset_l = 1'b1; Req = 4'hF;
    tick(); tick(); tick();
    Reset_l = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({Gnt, OE_l, Owner, Busy} !== {4'h0, 4'hF, 2'd0, 1'b0})
        $display("FAIL reset_mid_own cyc %0d: got %h want %h", i, {Gnt, OE_l, Owner, Busy}, {4'h0, 4'hF, 2'd0, 1'b0});
      else n_pass++;
    end
    Reset_l = 1'b1;
    tick();
    n_checks++;
    if (Gnt !== 4'b0001) $display("FAIL reset_first_grant: got %b want %b", Gnt, 4'b0001);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [3:0]  rq [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    logic [10:0] ex [6];
    ex[0] = {4'b0010, 4'b1101, 2'd1, 1'b1};
    ex[1] = ex[0];
    ex[2] = ex[0];
    ex[3] = {4'b0000, 4'b1111, 2'd1, 1'b1};
    ex[4] = ex[3];
    ex[5] = {4'b0000, PARK ? 4'b1101 : 4'b1111, 2'd1, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      Req = rq[i];
      tick();
      n_checks++;
      if ({Gnt, OE_l, Owner, Busy} !== ex[i])
        $display("FAIL single edge %0d: got %h want %h", i, {Gnt, OE_l, Owner, Busy}, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset();
    Req = 4'hF;
    for (int k = 0; k < 42; k++) begin
      tick();
      eg = ((k % 10) < MAXHOLD) ? 4'(1 << ((k / 10) % NREQ)) : 4'h0;
      n_checks++;
      if ({Gnt, OE_l} !== {eg, ~eg})
        $display("FAIL round_robin cyc %0d: got gnt %b oe %b want gnt %b oe %b", k, Gnt, OE_l, eg, ~eg);
      else n_pass++;
      n_checks++;
      if ($countones(~OE_l) > 1) $display("FAIL rr_one_oe cyc %0d: got oe %b want at most one low", k, OE_l);
      else n_pass++;
    end
  endtask

  task automatic test_no_contention();
    do_reset();
    Req = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if ({Gnt, OE_l, Busy} !== {4'b0001, 4'b1110, 1'b1})
        $display("FAIL no_contention cyc %0d: got %h want %h", k, {Gnt, OE_l, Busy}, {4'b0001, 4'b1110, 1'b1});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_turn();
    do_reset();
    Req = 4'b0100; tick();
    Req = 4'b0000; tick();
    Reset_l = 1'b0; tick();
    n_checks++;
    if ({Gnt, OE_l, Owner, Busy} !== {4'h0, 4'hF, 2'd0, 1'b0})
      $display("FAIL reset_mid_turn: got %h want %h", {Gnt, OE_l, Owner, Busy}, {4'h0, 4'hF, 2'd0, 1'b0});
    else n_pass++;
    Reset_l = 1'b1; Req = 4'b1010; tick();
    n_checks++;
    if ({Gnt, Owner} !== {4'b0010, 2'd1})
      $display("FAIL ptr_after_reset: got gnt %b owner %0d want gnt 0010 owner 1", Gnt, Owner);
    else n_pass++;
  endtask

`ifdef BUS_ARB_PARK_EN
  task automatic test_parking();
    do_reset();
    Req = 4'b0100; tick();
    Req = 4'b0000; tick(); tick(); tick();
    n_checks++;
    if ({Gnt, OE_l, Busy} !== {4'h0, 4'b1011, 1'b0})
      $display("FAIL park_idle: got %h want %h", {Gnt, OE_l, Busy}, {4'h0, 4'b1011, 1'b0});
    else n_pass++;
    Req = 4'b0100; tick();
    n_checks++;
    if (Gnt !== 4'b0100) $display("FAIL park_regrant: got %b want 0100", Gnt);
    else n_pass++;
    Req = 4'b0000; tick(); tick(); tick();
    Req = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({Gnt, OE_l} !== {4'h0, 4'hF}) $display("FAIL park_turn cyc %0d: got %h want 0f", i, {Gnt, OE_l});
      else n_pass++;
    end
    tick();
    n_checks++;
    if (Gnt !== 4'b0001) $display("FAIL park_other_grant: got %b want 0001", Gnt);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic [3:0]  flips;
    logic [10:0] ex;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < NREQ; b++) flips[b] = ($urandom_range(0, 9) == 0);
      Req     = Req ^ flips;
      Reset_l = ($urandom_range(0, 79) != 0);
      tick();
      ex = model_out();
      n_checks++;
      if ({Gnt, OE_l, Owner, Busy} !== ex)
        $display("FAIL random cyc %0d: got %h want %h", k, {Gnt, OE_l, Owner, Busy}, ex);
      else n_pass++;
      n_checks++;
      if ($countones(~OE_l) > 1) $display("FAIL random_one_oe cyc %0d: got oe %b want at most one low", k, OE_l);
      else n_pass++;
    end
    Reset_l = 1'b1;
  endtask

  initial begin
    Reset_l = 1'b0;
    Req     = 4'h0;
    m_mode = 0; m_owner = 0; m_ptr = 0; m_ten = 0; m_turn = 0; m_parked = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_no_contention();
    test_reset_mid_turn();
`ifdef BUS_ARB_PARK_EN
    test_parking();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
